// File: rtl/nn_waveform_driver.sv
// Collects a frame of waveform samples, hands it to an HLS-style accelerator
// through its ap_* block handshake, and returns the captured mean/sigma results.
module nn_waveform_driver #(
    parameter int N_SAMPLES   = 100,
    parameter int SAMPLE_W    = 18,
    parameter int OUT_W       = 24,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,

    input  logic [SAMPLE_W-1:0]           s_data,
    input  logic                          s_valid,
    output logic                          s_ready,

    output logic [N_SAMPLES*SAMPLE_W-1:0] nn_input_1,
    output logic                          nn_input_1_ap_vld,
    output logic                          nn_ap_start,
    input  logic                          nn_ap_done,
    input  logic                          nn_ap_idle,
    input  logic                          nn_ap_ready,
    input  logic [OUT_W-1:0]              nn_layer5_out_0,
    input  logic [OUT_W-1:0]              nn_layer5_out_1,
    input  logic                          nn_layer5_out_0_ap_vld,
    input  logic                          nn_layer5_out_1_ap_vld,

    output logic [OUT_W-1:0]              res_mean,
    output logic [OUT_W-1:0]              res_sigma,
    output logic                          res_valid,
    output logic                          res_err,
    input  logic                          res_ready,
    output logic [15:0]                   frame_cnt
);

    localparam int IDX_W   = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam int TC_W    = $clog2(TIMEOUT_CYC + 1);
    localparam int FRAME_W = N_SAMPLES * SAMPLE_W;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);
    localparam logic [TC_W-1:0]  LAST_TC  = TC_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_FILL,
        ST_LAUNCH,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [OUT_W-1:0]   mean_q, mean_d;
    logic [OUT_W-1:0]   sigma_q, sigma_d;
    logic               err_q, err_d;
    logic               got0_q, got0_d;
    logic               got1_q, got1_d;
    logic [TC_W-1:0]    tcnt_q, tcnt_d;
    logic [15:0]        fcnt_q, fcnt_d;

    // ap_idle carries no information the FSM needs; it is kept for observability only.
    logic unused_idle;
    assign unused_idle = nn_ap_idle;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= ST_FILL;
            idx_q   <= '0;
            frame_q <= '0;
            mean_q  <= '0;
            sigma_q <= '0;
            err_q   <= 1'b0;
            got0_q  <= 1'b0;
            got1_q  <= 1'b0;
            tcnt_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            mean_q  <= mean_d;
            sigma_q <= sigma_d;
            err_q   <= err_d;
            got0_q  <= got0_d;
            got1_q  <= got1_d;
            tcnt_q  <= tcnt_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        mean_d  = mean_q;
        sigma_d = sigma_q;
        err_d   = err_q;
        got0_d  = got0_q;
        got1_d  = got1_q;
        tcnt_d  = tcnt_q;
        fcnt_d  = fcnt_q;

        case (state_q)
            ST_FILL: begin
                if (s_valid) begin
                    frame_d[int'(idx_q)*SAMPLE_W +: SAMPLE_W] = s_data;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_LAUNCH;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            ST_LAUNCH: begin
                if (nn_ap_ready) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (nn_layer5_out_0_ap_vld) begin
                    mean_d = nn_layer5_out_0;
                    got0_d = 1'b1;
                end
                if (nn_layer5_out_1_ap_vld) begin
                    sigma_d = nn_layer5_out_1;
                    got1_d  = 1'b1;
                end
                // A done in the final budgeted cycle still counts as a real completion.
                if (nn_ap_done) begin
                    state_d = ST_HOLD;
                    err_d   = !(got0_q || nn_layer5_out_0_ap_vld) ||
                              !(got1_q || nn_layer5_out_1_ap_vld);
                end else if (tcnt_q == LAST_TC) begin
                    state_d = ST_HOLD;
                    err_d   = 1'b1;
                    mean_d  = '0;
                    sigma_d = '0;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end

            ST_HOLD: begin
                if (res_ready) begin
                    state_d = ST_FILL;
                    got0_d  = 1'b0;
                    got1_d  = 1'b0;
                    tcnt_d  = '0;
                    err_d   = 1'b0;
                    fcnt_d  = fcnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    assign s_ready           = (state_q == ST_FILL);
    assign nn_ap_start       = (state_q == ST_LAUNCH);
    assign nn_input_1_ap_vld = (state_q == ST_LAUNCH);
    assign res_valid         = (state_q == ST_HOLD);
    assign nn_input_1        = frame_q;
    assign res_mean          = mean_q;
    assign res_sigma         = sigma_q;
    assign res_err           = err_q;
    assign frame_cnt         = fcnt_q;

endmodule

// File: tb/tb_nn_waveform_driver.sv
// Directed self-checking bench for nn_waveform_driver: the bench plays the
// accelerator side and compares against hand-computed frames and results.
module tb_nn_waveform_driver;

    localparam int N  = 100;
    localparam int SW = 18;
    localparam int OW = 24;
    localparam int TO = 4096;
    localparam int FW = N * SW;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic [SW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [FW-1:0] nn_input_1;
    logic          nn_input_1_ap_vld;
    logic          nn_ap_start;
    logic          nn_ap_done = 1'b0;
    logic          nn_ap_idle = 1'b1;
    logic          nn_ap_ready = 1'b0;
    logic [OW-1:0] out0 = '0;
    logic [OW-1:0] out1 = '0;
    logic          vld0 = 1'b0;
    logic          vld1 = 1'b0;
    logic [OW-1:0] res_mean;
    logic [OW-1:0] res_sigma;
    logic          res_valid;
    logic          res_err;
    logic          res_ready = 1'b0;
    logic [15:0]   frame_cnt;

    int checks = 0;
    int errors = 0;
    logic [FW-1:0] expFrame;

    nn_waveform_driver #(
        .N_SAMPLES(N), .SAMPLE_W(SW), .OUT_W(OW), .TIMEOUT_CYC(TO)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .nn_input_1(nn_input_1), .nn_input_1_ap_vld(nn_input_1_ap_vld),
        .nn_ap_start(nn_ap_start), .nn_ap_done(nn_ap_done),
        .nn_ap_idle(nn_ap_idle), .nn_ap_ready(nn_ap_ready),
        .nn_layer5_out_0(out0), .nn_layer5_out_1(out1),
        .nn_layer5_out_0_ap_vld(vld0), .nn_layer5_out_1_ap_vld(vld1),
        .res_mean(res_mean), .res_sigma(res_sigma),
        .res_valid(res_valid), .res_err(res_err), .res_ready(res_ready),
        .frame_cnt(frame_cnt)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic send_samples(input int count, input int base);
        for (int k = 0; k < count; k++) begin
            s_data  = SW'(base + k);
            s_valid = 1'b1;
            step();
        end
        s_valid = 1'b0;
    endtask

    task automatic build_frame(input int base);
        expFrame = '0;
        for (int k = 0; k < N; k++) begin
            expFrame[k*SW +: SW] = SW'(base + k);
        end
    endtask

    task automatic launch_to_wait();
        int n;
        n = 0;
        while (nn_ap_start !== 1'b1 && n < 5) begin
            step();
            n++;
        end
        checks++;
        if (nn_ap_start !== 1'b1) begin
            errors++;
            $display("[TB] FAIL launch_wait: nn_ap_start=%b required 1", nn_ap_start);
        end
        nn_ap_ready = 1'b1;
        step();
        nn_ap_ready = 1'b0;
    endtask

    task automatic complete_frame();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({nn_ap_start, nn_input_1_ap_vld, res_valid, res_err} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: start/vld/res_valid/err=%b required 0000",
                     {nn_ap_start, nn_input_1_ap_vld, res_valid, res_err});
        end
        checks++;
        if (res_mean !== '0 || res_sigma !== '0 || frame_cnt !== 16'd0 || nn_input_1 !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: mean=%h sigma=%h cnt=%0d required all zero",
                     res_mean, res_sigma, frame_cnt);
        end
        ap_rst_n = 1'b1;
        step();
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_sready: s_ready=%b required 1", s_ready);
        end
    endtask

    task automatic test_fill_launch();
        build_frame(1);
        send_samples(N - 1, 1);
        checks++;
        if (nn_ap_start !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fill_early: start=%b s_ready=%b required 0 1", nn_ap_start, s_ready);
        end
        send_samples(1, N);
        checks++;
        if (nn_ap_start !== 1'b1 || nn_input_1_ap_vld !== 1'b1 || s_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fill_launch: start=%b vld=%b s_ready=%b required 1 1 0",
                     nn_ap_start, nn_input_1_ap_vld, s_ready);
        end
        checks++;
        if (nn_input_1[17:0] !== 18'd1 || nn_input_1[1799:1782] !== 18'd100) begin
            errors++;
            $display("[TB] FAIL fill_slots: slot0=%0d slot99=%0d required 1 100",
                     nn_input_1[17:0], nn_input_1[1799:1782]);
        end
        checks++;
        if (nn_input_1 !== expFrame) begin
            errors++;
            $display("[TB] FAIL fill_frame: slot1=%0d slot50=%0d required 2 51",
                     nn_input_1[35:18], nn_input_1[917:900]);
        end
        // Samples offered while launching must not touch the frame.
        s_data  = 18'h3FFFF;
        s_valid = 1'b1;
        step();
        step();
        s_valid = 1'b0;
        checks++;
        if (nn_ap_start !== 1'b1 || nn_input_1 !== expFrame) begin
            errors++;
            $display("[TB] FAIL launch_hold: start=%b slot0=%0d required 1 1",
                     nn_ap_start, nn_input_1[17:0]);
        end
        nn_ap_ready = 1'b1;
        step();
        nn_ap_ready = 1'b0;
        checks++;
        if (nn_ap_start !== 1'b0 || nn_input_1_ap_vld !== 1'b0) begin
            errors++;
            $display("[TB] FAIL launch_drop: start=%b vld=%b required 0 0",
                     nn_ap_start, nn_input_1_ap_vld);
        end
    endtask

    task automatic test_result();
        out0 = 24'h000123;
        vld0 = 1'b1;
        step();
        vld0 = 1'b0;
        out1 = 24'h000456;
        vld1 = 1'b1;
        step();
        vld1 = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || nn_input_1 !== expFrame) begin
            errors++;
            $display("[TB] FAIL result_early: res_valid=%b required 0", res_valid);
        end
        nn_ap_done = 1'b1;
        step();
        nn_ap_done = 1'b0;
        checks++;
        if (res_valid !== 1'b1 || res_mean !== 24'h000123 || res_sigma !== 24'h000456 || res_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL result_hold: valid=%b mean=%h sigma=%h err=%b required 1 000123 000456 0",
                     res_valid, res_mean, res_sigma, res_err);
        end
        complete_frame();
        checks++;
        if (frame_cnt !== 16'd1 || res_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL result_done: cnt=%0d valid=%b s_ready=%b required 1 0 1",
                     frame_cnt, res_valid, s_ready);
        end
    endtask

    task automatic test_done_same_cycle();
        send_samples(N, 32'h200);
        launch_to_wait();
        out0 = 24'h000AAA;
        out1 = 24'h000BBB;
        vld0 = 1'b1;
        vld1 = 1'b1;
        nn_ap_done = 1'b1;
        step();
        vld0 = 1'b0;
        vld1 = 1'b0;
        nn_ap_done = 1'b0;
        checks++;
        if (res_valid !== 1'b1 || res_mean !== 24'h000AAA || res_sigma !== 24'h000BBB || res_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL same_cycle: valid=%b mean=%h sigma=%h err=%b required 1 000aaa 000bbb 0",
                     res_valid, res_mean, res_sigma, res_err);
        end
        complete_frame();
        checks++;
        if (frame_cnt !== 16'd2) begin
            errors++;
            $display("[TB] FAIL same_cycle_cnt: cnt=%0d required 2", frame_cnt);
        end
    endtask

    task automatic test_missing_result();
        send_samples(N, 32'h300);
        launch_to_wait();
        out0 = 24'h000777;
        vld0 = 1'b1;
        step();
        vld0 = 1'b0;
        nn_ap_done = 1'b1;
        step();
        nn_ap_done = 1'b0;
        checks++;
        if (res_valid !== 1'b1 || res_err !== 1'b1 || res_mean !== 24'h000777) begin
            errors++;
            $display("[TB] FAIL missing_sigma: valid=%b err=%b mean=%h required 1 1 000777",
                     res_valid, res_err, res_mean);
        end
        complete_frame();
        checks++;
        if (frame_cnt !== 16'd3 || res_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL missing_cnt: cnt=%0d err=%b required 3 0", frame_cnt, res_err);
        end
    endtask

    task automatic test_timeout();
        int n;
        send_samples(N, 32'h40);
        launch_to_wait();
        vld0 = 1'b1;
        out0 = 24'h000999;
        step();
        vld0 = 1'b0;
        n = 1;
        while (res_valid !== 1'b1 && n < TO + 100) begin
            step();
            n++;
        end
        checks++;
        if (n !== TO) begin
            errors++;
            $display("[TB] FAIL timeout_len: wait cycles=%0d required %0d", n, TO);
        end
        checks++;
        if (res_valid !== 1'b1 || res_err !== 1'b1 || res_mean !== '0 || res_sigma !== '0) begin
            errors++;
            $display("[TB] FAIL timeout_res: valid=%b err=%b mean=%h sigma=%h required 1 1 0 0",
                     res_valid, res_err, res_mean, res_sigma);
        end
        complete_frame();
        checks++;
        if (frame_cnt !== 16'd4) begin
            errors++;
            $display("[TB] FAIL timeout_cnt: cnt=%0d required 4", frame_cnt);
        end
    endtask

    task automatic test_hold_stall();
        build_frame(32'h400);
        send_samples(N, 32'h400);
        launch_to_wait();
        out0 = 24'h000321;
        out1 = 24'h000654;
        vld0 = 1'b1;
        vld1 = 1'b1;
        nn_ap_done = 1'b1;
        step();
        vld0 = 1'b0;
        vld1 = 1'b0;
        nn_ap_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            s_data  = SW'(32'h15555 + c);
            s_valid = 1'b1;
            step();
            checks++;
            if (res_valid !== 1'b1 || s_ready !== 1'b0 || res_mean !== 24'h000321 ||
                res_sigma !== 24'h000654 || res_err !== 1'b0 || nn_input_1 !== expFrame) begin
                errors++;
                $display("[TB] FAIL hold_stall[%0d]: valid=%b s_ready=%b mean=%h sigma=%h err=%b slot0=%h required 1 0 000321 000654 0 00400",
                         c, res_valid, s_ready, res_mean, res_sigma, res_err, nn_input_1[17:0]);
            end
        end
        s_valid = 1'b0;
        complete_frame();
        checks++;
        if (frame_cnt !== 16'd5 || nn_input_1 !== expFrame || s_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_release: cnt=%0d slot0=%h s_ready=%b required 5 00400 1",
                     frame_cnt, nn_input_1[17:0], s_ready);
        end
    endtask

    task automatic test_reset_mid_fill();
        send_samples(50, 32'h3000);
        #2;
        ap_rst_n = 1'b0;
        #1;
        checks++;
        if (nn_input_1 !== '0 || frame_cnt !== 16'd0 || nn_ap_start !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_async: slot0=%h cnt=%0d start=%b valid=%b required 0 0 0 0",
                     nn_input_1[17:0], frame_cnt, nn_ap_start, res_valid);
        end
        step();
        ap_rst_n = 1'b1;
        step();
        build_frame(32'h500);
        send_samples(N - 1, 32'h500);
        checks++;
        if (nn_ap_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_early: start=%b required 0", nn_ap_start);
        end
        send_samples(1, 32'h500 + N - 1);
        checks++;
        if (nn_ap_start !== 1'b1 || nn_input_1 !== expFrame || nn_input_1[899:882] !== 18'h531) begin
            errors++;
            $display("[TB] FAIL midreset_frame: start=%b slot0=%h slot49=%h required 1 00500 00531",
                     nn_ap_start, nn_input_1[17:0], nn_input_1[899:882]);
        end
        launch_to_wait();
        out0 = 24'h000011;
        out1 = 24'h000022;
        vld0 = 1'b1;
        vld1 = 1'b1;
        nn_ap_done = 1'b1;
        step();
        vld0 = 1'b0;
        vld1 = 1'b0;
        nn_ap_done = 1'b0;
        complete_frame();
        checks++;
        if (frame_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL midreset_cnt: cnt=%0d required 1", frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_fill_launch();
        test_result();
        test_done_same_cycle();
        test_missing_result();
        test_timeout();
        test_hold_stall();
        test_reset_mid_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nn_waveform_driver.md
NN_WAVEFORM_DRIVER -- requirements
Module: nn_waveform_driver

Interface
REQ-001 SHALL have parameter N_SAMPLES, 100, waveform samples per inference frame.
REQ-002 SHALL have parameter SAMPLE_W, 18, sample width in bits (fixed-point word as consumed by the accelerator).
REQ-003 SHALL have parameter OUT_W, 24, accelerator result word width.
REQ-004 SHALL have parameter TIMEOUT_CYC, 4096, maximum cycles waited for ap_done after launch.
REQ-005 SHALL have port ap_clk  in  1  sole clock, all logic rising-edge.
REQ-006 SHALL have port ap_rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port s_data  in  SAMPLE_W  incoming waveform sample.
REQ-008 SHALL have port s_valid  in  1  s_data valid.
REQ-009 SHALL have port s_ready  out  1  driver accepts a sample this cycle.
REQ-010 SHALL have port nn_input_1  out  N_SAMPLES*SAMPLE_W  packed frame to accelerator, sample 0 in bits [SAMPLE_W-1:0].
REQ-011 SHALL have ports nn_input_1_ap_vld, nn_ap_start  out  1 each  accelerator input-valid and start.
REQ-012 SHALL have ports nn_ap_done, nn_ap_idle, nn_ap_ready  in  1 each  accelerator block-level handshake.
REQ-013 SHALL have ports nn_layer5_out_0, nn_layer5_out_1  in  OUT_W each  accelerator mean and sigma results.
REQ-014 SHALL have ports nn_layer5_out_0_ap_vld, nn_layer5_out_1_ap_vld  in  1 each  per-result valid strobes.
REQ-015 SHALL have ports res_mean, res_sigma  out  OUT_W each  captured results.
REQ-016 SHALL have ports res_valid  out  1, res_err  out  1, res_ready  in  1  result handshake and error flag.
REQ-017 SHALL have port frame_cnt  out  16  completed frames, including errored ones.

Function
REQ-018 SHALL implement FSM states FILL, LAUNCH, WAIT, HOLD.
REQ-019 FILL: s_ready=1; each cycle with s_valid&&s_ready SHALL write s_data into slot idx of nn_input_1 and increment idx.
REQ-020 Accepting slot N_SAMPLES-1 SHALL set idx to 0 and move to LAUNCH the next cycle; nn_ap_start asserts the cycle after the 100th acceptance.
REQ-021 s_ready SHALL be 0 in LAUNCH, WAIT and HOLD; s_valid in those states SHALL be ignored with no slot change.
REQ-022 LAUNCH: nn_ap_start=1 and nn_input_1_ap_vld=1, both held until nn_ap_ready is sampled 1; that cycle SHALL move to WAIT, and both drop the following cycle.
REQ-023 nn_input_1 SHALL remain stable from entry to LAUNCH until return to FILL.
REQ-024 WAIT: nn_layer5_out_0_ap_vld SHALL capture nn_layer5_out_0 into res_mean and set got0; likewise out_1/res_sigma/got1; strobes may arrive in any order or together.
REQ-025 nn_ap_done=1 in WAIT SHALL move to HOLD; strobes in the same cycle as done SHALL be captured; res_err=1 if got0 or got1 is still 0 after that cycle.
REQ-026 WAIT SHALL count cycles; reaching TIMEOUT_CYC without done SHALL move to HOLD with res_err=1 and res_mean and res_sigma set to 0.
REQ-027 HOLD: res_valid=1 with res_mean, res_sigma, res_err stable; res_ready=1 SHALL complete in that cycle, return to FILL, clear got0, got1 and the timeout counter, and increment frame_cnt.
REQ-028 frame_cnt SHALL wrap 16'hFFFF -> 0.
REQ-029 Minimum HOLD residency SHALL be one cycle (res_ready held high).
REQ-030 nn_ap_idle SHALL be informational only and SHALL NOT affect state.

Reset
REQ-031 ap_rst_n=0 SHALL asynchronously force FILL, idx=0, nn_input_1=0, and nn_ap_start, nn_input_1_ap_vld, res_valid, res_err=0.
REQ-032 ap_rst_n=0 SHALL also force res_mean=0, res_sigma=0, frame_cnt=0; s_ready=1 after the first clock following deassertion.
REQ-033 Reset in any state, including mid-fill or WAIT, SHALL discard the partial frame; no res_valid SHALL result.

Verification
REQ-034 Stream 100 samples, sample k=k+1, s_valid constant -> ap_start rises the cycle after the 100th acceptance; nn_input_1[17:0]=1, [1799:1782]=100.
REQ-035 Model asserts ap_ready 3 cycles after start, out_0 vld=24'h000123, out_1 vld=24'h000456, then done -> res_valid=1, res_mean=24'h000123, res_sigma=24'h000456, res_err=0, frame_cnt=1.
REQ-036 Both vld strobes in the same cycle as done -> values captured, res_err=0.
REQ-037 Model never asserts done -> HOLD after exactly 4096 WAIT cycles, res_err=1, results 0.
REQ-038 Reset pulsed after 50 samples, then 100 fresh samples -> single launch whose frame holds only the fresh samples.
REQ-039 res_ready held low 20 cycles in HOLD -> outputs stable, s_ready=0, extra s_valid ignored.
